// File: rtl/axi4_s_w.sv
// -----------------------------------------------------------------------------
// axi4_s_w : AXI4 slave write responder for the QEMU PCIe bridge.
//
// Accepts a single AW burst, gathers its W beats into a DTMP-byte hand-off
// buffer with a per-byte "written" flag, pulses o_req_valid for one cycle so the
// QEMU side can pick the buffer up, waits for i_req_done and then returns one B
// response. Only one burst is ever outstanding and AW/W are never interleaved.
//
// The simulation wrapper issues C_req_write(o_req_addr, o_req_size, o_req_len,
// o_req_id) on the clock edge where o_req_valid is high. The captured burst
// fields are exported as ports so this module itself stays synthesizable.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_s_aw*                   AXI write address channel (awburst ignored: INCR)
//   i_s_w*, o_s_wready        AXI write data channel
//   o_s_b*, i_s_bready        AXI write response channel
//   o_req_data[DTMP]          gathered bytes, index STBW*beat + lane
//   o_req_strb[DTMP]          per-byte written flag
//   o_req_valid               one-cycle pulse: buffer ready for QEMU
//   o_req_addr/size/len/id    captured AW fields for the hand-off call
//   i_req_done                QEMU write completion (honoured only in WAIT)
// -----------------------------------------------------------------------------
module axi4_s_w #(
    parameter int TAGW  = 3,
    parameter int ADRW  = 32,
    parameter int DATW  = 256,
    parameter int STBW  = DATW / 8,
    parameter int DTMP  = 4096,
    parameter int NBEAT = DTMP / STBW
) (
    input  logic             i_clk,
    input  logic             i_rst,

    input  logic [TAGW-1:0]  i_s_awid,
    input  logic [ADRW-1:0]  i_s_awaddr,
    input  logic [7:0]       i_s_awlen,
    input  logic [2:0]       i_s_awsize,
    input  logic [1:0]       i_s_awburst,
    input  logic             i_s_awvalid,
    output logic             o_s_awready,

    input  logic [DATW-1:0]  i_s_wdata,
    input  logic [STBW-1:0]  i_s_wstrb,
    input  logic             i_s_wlast,
    input  logic             i_s_wvalid,
    output logic             o_s_wready,

    output logic [TAGW-1:0]  o_s_bid,
    output logic [1:0]       o_s_bresp,
    output logic             o_s_bvalid,
    input  logic             i_s_bready,

    output logic [7:0]       o_req_data [DTMP],
    output logic [DTMP-1:0]  o_req_strb,
    output logic             o_req_valid,
    output logic [ADRW-1:0]  o_req_addr,
    output logic [2:0]       o_req_size,
    output logic [7:0]       o_req_len,
    output logic [TAGW-1:0]  o_req_id,
    input  logic             i_req_done
);

    // Beat index width into the buffer; the beat counter itself is 9 bits so
    // it can count past 255 without wrapping when awlen=255.
    localparam int BIXW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Registered handshake / status outputs.
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic               r_req_valid;

    // Captured burst fields and progress.
    logic [TAGW-1:0]    r_id;
    logic [ADRW-1:0]    r_addr;
    logic [7:0]         r_len;
    logic [2:0]         r_size;
    logic [8:0]         r_cnt;
    logic               r_err;
    logic [TAGW-1:0]    r_bid;
    logic [1:0]         r_bresp;

    // Hand-off buffer, organised by beat so a W beat writes one row.
    logic [7:0]         r_data [NBEAT][STBW];
    logic [STBW-1:0]    r_strb [NBEAT];

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_cnt_at_len;
    logic               w_w_end;
    logic               w_in_range;
    logic [BIXW-1:0]    w_beat_idx;
    logic               w_unused_ok;

    // awburst is deliberately ignored; the QEMU side assumes INCR.
    assign w_unused_ok  = ^i_s_awburst;

    assign w_aw_hs      = i_s_awvalid & r_awready;
    assign w_w_hs       = i_s_wvalid & r_wready;
    assign w_b_hs       = r_bvalid & i_s_bready;
    assign w_cnt_at_len = (r_cnt == {1'b0, r_len});
    // The burst ends on whichever comes first: wlast or the awlen-th beat.
    assign w_w_end      = w_w_hs & (i_s_wlast | w_cnt_at_len);
    assign w_in_range   = (32'(r_cnt) < NBEAT);
    assign w_beat_idx   = r_cnt[BIXW-1:0];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_aw_hs)    w_state_next = S_DATA;
            S_DATA: if (w_w_end)    w_state_next = S_REQ;
            S_REQ:                  w_state_next = S_WAIT;
            S_WAIT: if (i_req_done) w_state_next = S_RESP;
            S_RESP: if (w_b_hs)     w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake outputs are registered decodes of the next state, so each one
    // changes on the same edge the FSM enters/leaves the owning state.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_awready   <= 1'b1;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_req_valid <= 1'b0;
        end else begin
            r_awready   <= (w_state_next == S_IDLE);
            r_wready    <= (w_state_next == S_DATA);
            r_bvalid    <= (w_state_next == S_RESP);
            r_req_valid <= (w_state_next == S_REQ);
        end
    end

    // -------------------------------------------------------------------------
    // Burst capture, beat counting, error tracking and B fields
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_bid   <= '0;
            r_bresp <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_id   <= i_s_awid;
                r_addr <= i_s_awaddr;
                r_len  <= i_s_awlen;
                r_size <= i_s_awsize;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (w_w_hs) begin
                r_cnt <= r_cnt + 9'd1;
                // Early wlast, missing wlast, or a beat past the buffer end.
                if (!w_in_range || (i_s_wlast != w_cnt_at_len)) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == S_WAIT) && i_req_done) begin
                r_bid   <= r_id;
                r_bresp <= r_err ? 2'b10 : 2'b00;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Hand-off buffer. Data is only zeroed by reset; strobes are cleared at
    // every AW accept so they describe exactly the current burst.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NBEAT; b++) begin
                r_strb[b] <= '0;
                for (int l = 0; l < STBW; l++) begin
                    r_data[b][l] <= 8'h00;
                end
            end
        end else begin
            if (w_aw_hs) begin
                for (int b = 0; b < NBEAT; b++) begin
                    r_strb[b] <= '0;
                end
            end
            if (w_w_hs && w_in_range) begin
                for (int l = 0; l < STBW; l++) begin
                    if (i_s_wstrb[l]) begin
                        r_data[w_beat_idx][l] <= i_s_wdata[8*l +: 8];
                        r_strb[w_beat_idx][l] <= 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Flatten the beat-organised buffer onto the byte-indexed outputs.
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < NBEAT; gi++) begin : g_beat
            for (gj = 0; gj < STBW; gj++) begin : g_lane
                assign o_req_data[gi*STBW + gj] = r_data[gi][gj];
            end
            assign o_req_strb[gi*STBW +: STBW] = r_strb[gi];
        end
    endgenerate

    assign o_s_awready = r_awready;
    assign o_s_wready  = r_wready;
    assign o_s_bvalid  = r_bvalid;
    assign o_s_bid     = r_bid;
    assign o_s_bresp   = r_bresp;
    assign o_req_valid = r_req_valid;
    assign o_req_addr  = r_addr;
    assign o_req_size  = r_size;
    assign o_req_len   = r_len;
    assign o_req_id    = r_id;

endmodule

// File: tb/tb_axi4_s_w.sv
// -----------------------------------------------------------------------------
// tb_axi4_s_w : randomized self-checking bench for axi4_s_w.
// The reference model is a plain byte array plus a strobe vector updated per
// accepted beat; expected error/termination come from the burst rules.
// -----------------------------------------------------------------------------
module tb_axi4_s_w;

    localparam int TAGW  = 3;
    localparam int ADRW  = 32;
    localparam int DATW  = 256;
    localparam int STBW  = DATW / 8;
    localparam int DTMP  = 4096;
    localparam int NBEAT = DTMP / STBW;

    logic              clk = 1'b0;
    logic              rst;
    logic [TAGW-1:0]   s_awid;
    logic [ADRW-1:0]   s_awaddr;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              s_awvalid;
    logic              s_awready;
    logic [DATW-1:0]   s_wdata;
    logic [STBW-1:0]   s_wstrb;
    logic              s_wlast;
    logic              s_wvalid;
    logic              s_wready;
    logic [TAGW-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [7:0]        req_data [DTMP];
    logic [DTMP-1:0]   req_strb;
    logic              req_valid;
    logic [ADRW-1:0]   req_addr;
    logic [2:0]        req_size;
    logic [7:0]        req_len;
    logic [TAGW-1:0]   req_id;
    logic              req_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        m_data [DTMP];
    logic [DTMP-1:0]   m_strb;

    always #5 clk = ~clk;

    axi4_s_w #(
        .TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .STBW(STBW), .DTMP(DTMP), .NBEAT(NBEAT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s_awid(s_awid), .i_s_awaddr(s_awaddr), .i_s_awlen(s_awlen),
        .i_s_awsize(s_awsize), .i_s_awburst(s_awburst), .i_s_awvalid(s_awvalid),
        .o_s_awready(s_awready),
        .i_s_wdata(s_wdata), .i_s_wstrb(s_wstrb), .i_s_wlast(s_wlast),
        .i_s_wvalid(s_wvalid), .o_s_wready(s_wready),
        .o_s_bid(s_bid), .o_s_bresp(s_bresp), .o_s_bvalid(s_bvalid), .i_s_bready(s_bready),
        .o_req_data(req_data), .o_req_strb(req_strb), .o_req_valid(req_valid),
        .o_req_addr(req_addr), .o_req_size(req_size), .o_req_len(req_len), .o_req_id(req_id),
        .i_req_done(req_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DTMP; i++) m_data[i] = 8'h00;
        m_strb = '0;
    endtask

    task automatic check_buffer(input string tag);
        int nbad_d = 0;
        int nbad_s = 0;
        for (int i = 0; i < DTMP; i++) begin
            if (req_data[i] !== m_data[i]) nbad_d++;
            if (req_strb[i] !== m_strb[i]) nbad_s++;
        end
        check({tag, "_data_bad_bytes"}, 64'(nbad_d), 0);
        check({tag, "_strb_bad_bits"}, 64'(nbad_s), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_clear();
    endtask

    // mode 0: random data, full strobes; 1: byte index pattern; 2: strb 0xF; 3: random strobes
    task automatic gen_beat(input int mode, input int k);
        for (int w = 0; w < DATW / 32; w++) s_wdata[w*32 +: 32] = $urandom;
        s_wstrb = '1;
        if (mode == 1) begin
            for (int l = 0; l < STBW; l++) s_wdata[l*8 +: 8] = 8'((k * STBW + l) & 255);
        end else if (mode == 2) begin
            s_wstrb = 32'h0000_000F;
        end else if (mode == 3) begin
            s_wstrb = $urandom;
        end
    endtask

    // Waits until the selected ready is seen high before an edge (0: AW, 1: W).
    task automatic wait_hs(input int sel, input string tag);
        int  n = 0;
        logic r;
        forever begin
            r = (sel == 0) ? s_awready : s_wready;
            tick();
            if (r) return;
            n++;
            if (n > 200) begin
                check({tag, "_timeout"}, 64'(r), 1);
                return;
            end
        end
    endtask

    task automatic run_burst(input logic [TAGW-1:0] id, input logic [ADRW-1:0] addr,
                             input int len, input int wl_beat, input int mode,
                             input bit early_w, input int bdelay, input bit rst_in_wait);
        int   nb;
        logic exp_err;
        nb      = (wl_beat >= 0 && wl_beat < len) ? wl_beat + 1 : len + 1;
        exp_err = (wl_beat != len) || (nb > NBEAT);

        s_awid    = id;
        s_awaddr  = addr;
        s_awlen   = 8'(len);
        s_awsize  = 3'd5;
        s_awburst = 2'($urandom_range(0, 3));
        s_awvalid = 1'b1;
        if (early_w) begin
            gen_beat(mode, 0);
            s_wlast  = (wl_beat == 0);
            s_wvalid = 1'b1;
        end
        wait_hs(0, "aw");
        s_awvalid = 1'b0;
        m_strb    = '0;
        check("aw_accept_ready", {62'b0, s_awready, s_wready}, 64'b01);

        for (int k = 0; k < nb; k++) begin
            if (!(early_w && k == 0)) begin
                s_wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    req_done = 1'($urandom_range(0, 1));
                    tick();
                end
                gen_beat(mode, k);
                s_wlast  = (k == wl_beat);
                s_wvalid = 1'b1;
            end
            req_done = 1'($urandom_range(0, 1));
            wait_hs(1, "w");
            if (k < NBEAT) begin
                for (int l = 0; l < STBW; l++) begin
                    if (s_wstrb[l]) begin
                        m_data[k*STBW + l] = s_wdata[l*8 +: 8];
                        m_strb[k*STBW + l] = 1'b1;
                    end
                end
            end
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        // REQ cycle: done is noise here and must be ignored.
        req_done = 1'($urandom_range(0, 1));
        check("req_pulse_wready", {62'b0, req_valid, s_wready}, 64'b10);
        check_buffer("req");
        check("req_fields", {req_id, req_len, req_size, req_addr}, {id, 8'(len), 3'd5, addr});
        tick();
        req_done = 1'b0;
        check("req_single_pulse", {63'b0, req_valid}, 0);

        if (rst_in_wait) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_clear();
            check("rst_wait_state", {59'b0, s_awready, s_wready, s_bvalid, req_valid, s_bresp == 2'b00},
                  64'b10001);
            check_buffer("rst_wait");
            for (int c = 0; c < 4; c++) begin
                tick();
                check("rst_wait_no_b", {63'b0, s_bvalid}, 0);
            end
            return;
        end

        repeat ($urandom_range(0, 3)) begin
            tick();
            check("wait_no_b", {63'b0, s_bvalid}, 0);
        end
        req_done = 1'b1;
        tick();
        req_done = 1'b0;
        check("b_resp", {59'b0, s_bvalid, s_bid, s_bresp[0]}, {59'b0, 1'b1, id, 1'b0});
        check("b_bresp", {62'b0, s_bresp}, exp_err ? 2'b10 : 2'b00);
        s_bready = 1'b0;
        for (int c = 0; c < bdelay; c++) begin
            tick();
            check("b_hold", {57'b0, s_bvalid, s_awready, s_bid, s_bresp},
                  {57'b0, 1'b1, 1'b0, id, exp_err ? 2'b10 : 2'b00});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("b_done_idle", {62'b0, s_bvalid, s_awready}, 64'b01);
    endtask

    initial begin
        rst       = 1'b1;
        s_awid    = '0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_awburst = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        req_done  = 1'b0;
        do_reset();

        check("reset_ctrl", {59'b0, s_awready, s_wready, s_bvalid, req_valid, 1'b0}, 64'b10000);
        check("reset_b", {59'b0, s_bid, s_bresp}, 0);
        check_buffer("reset");

        // Single beat, byte-index pattern.
        run_burst(3'd5, 32'h0000_1000, 0, 0, 1, 1'b0, 0, 1'b0);
        // Four beats with random gaps.
        run_burst(3'd2, 32'h0000_2000, 3, 3, 0, 1'b0, 1, 1'b0);
        // Partial strobes straight after reset: untouched bytes stay zero.
        do_reset();
        run_burst(3'd1, 32'h0000_3000, 1, 1, 2, 1'b0, 0, 1'b0);
        // Early wlast.
        run_burst(3'd3, 32'h0000_4000, 3, 1, 0, 1'b0, 0, 1'b0);
        // No wlast at awlen.
        run_burst(3'd4, 32'h0000_4100, 2, -1, 3, 1'b0, 0, 1'b0);
        // bready held low five cycles, W presented together with AW.
        run_burst(3'd6, 32'h0000_5000, 1, 1, 0, 1'b1, 5, 1'b0);
        // Reset while waiting for completion, then a normal burst.
        run_burst(3'd7, 32'h0000_6000, 2, 2, 0, 1'b0, 0, 1'b1);
        run_burst(3'd0, 32'h0000_7000, 1, 1, 1, 1'b0, 0, 1'b0);
        // Burst longer than the buffer.
        run_burst(3'd2, 32'h0000_8000, 130, 130, 0, 1'b0, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            int len;
            int wl;
            len = $urandom_range(0, 7);
            wl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : len;
            run_burst(3'($urandom), $urandom, len, wl, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
